// File: rtl/led_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_source
//  Purpose  : CPU-mapped LED pattern register with blink/rotate animation.
//             The display word is handed to the serial LED driver only on its
//             frame boundary, so every frame shows one coherent pattern.
//  Revision : 1.0  initial release
// ============================================================================
module led_pattern_source #(
    parameter int PRESCALE = 50000
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_WE,
    input  logic [1:0]  i_Addr,
    input  logic [15:0] i_WData,
    output logic [15:0] o_RData,
    input  logic        i_FrameSync,
    output logic [15:0] o_Data16
);

    localparam int                      c_PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRESC_W-1:0]    c_PRESC_MAX = c_PRESC_W'(PRESCALE - 1);

    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_MODE   = 2'd1;
    localparam logic [1:0] c_ADDR_PERIOD = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS = 2'd3;

    localparam logic [1:0] c_ANIM_STATIC = 2'd0;
    localparam logic [1:0] c_ANIM_BLINK  = 2'd1;
    localparam logic [1:0] c_ANIM_ROTL   = 2'd2;
    localparam logic [1:0] c_ANIM_ROTR   = 2'd3;

    logic [15:0]          r_w;
    logic [2:0]           r_mode;
    logic [15:0]          r_period;
    logic                 r_phase;
    logic [c_PRESC_W-1:0] r_presc;
    logic [15:0]          r_step;
    logic [7:0]           r_frame;

    logic        w_wr_data;
    logic        w_wr_mode;
    logic        w_wr_period;
    logic        w_wr_status;
    logic        w_tick;
    logic [15:0] w_period_m1;
    logic        w_step_evt;
    logic        w_step_apply;
    logic        w_enable;
    logic [1:0]  w_anim;
    logic [15:0] w_shown;

    assign w_wr_data   = i_WE && (i_Addr == c_ADDR_DATA);
    assign w_wr_mode   = i_WE && (i_Addr == c_ADDR_MODE);
    assign w_wr_period = i_WE && (i_Addr == c_ADDR_PERIOD);
    assign w_wr_status = i_WE && (i_Addr == c_ADDR_STATUS);

    assign w_enable    = r_mode[2];
    assign w_anim      = r_mode[1:0];

    // A PERIOD of zero is treated as one tick per step.
    assign w_period_m1 = (r_period == 16'd0) ? 16'd0 : (r_period - 16'd1);
    assign w_tick      = (r_presc == c_PRESC_MAX);
    assign w_step_evt  = w_tick && (r_step == w_period_m1);
    // Any register write in the same cycle swallows the step.
    assign w_step_apply = w_step_evt && w_enable && !i_WE;

    // Word the driver would display right now, from current register state.
    always_comb begin
        w_shown = r_w;
        if (!w_enable) begin
            w_shown = 16'h0000;
        end else if ((w_anim == c_ANIM_BLINK) && r_phase) begin
            w_shown = 16'h0000;
        end
    end

    // Free-running tick prescaler, restarted by DATA/MODE writes.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_presc <= '0;
        end else if (w_wr_data || w_wr_mode || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Step counter: counts ticks up to the programmed period.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_step <= 16'd0;
        end else if (w_wr_data || w_wr_mode || w_wr_period) begin
            r_step <= 16'd0;
        end else if (w_tick) begin
            r_step <= w_step_evt ? 16'd0 : (r_step + 16'd1);
        end
    end

    // Working pattern and blink phase: CPU writes, else animation steps.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_w     <= 16'h0000;
            r_phase <= 1'b0;
        end else if (w_wr_data) begin
            r_w     <= i_WData;
            r_phase <= 1'b0;
        end else if (w_wr_mode) begin
            r_phase <= 1'b0;
        end else if (w_step_apply) begin
            case (w_anim)
                c_ANIM_STATIC: r_w     <= r_w;
                c_ANIM_BLINK:  r_phase <= ~r_phase;
                c_ANIM_ROTL:   r_w     <= {r_w[14:0], r_w[15]};
                c_ANIM_ROTR:   r_w     <= {r_w[0], r_w[15:1]};
                default:       r_w     <= r_w;
            endcase
        end
    end

    // MODE and PERIOD configuration registers.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_mode   <= 3'd0;
            r_period <= 16'd1;
        end else begin
            if (w_wr_mode) begin
                r_mode <= i_WData[2:0];
            end
            if (w_wr_period) begin
                r_period <= i_WData;
            end
        end
    end

    // Frame counter; a STATUS write clear beats a coincident frame pulse.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_frame <= 8'd0;
        end else if (w_wr_status) begin
            r_frame <= 8'd0;
        end else if (i_FrameSync) begin
            r_frame <= r_frame + 8'd1;
        end
    end

    // Display word is only handed over on the driver's frame boundary.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            o_Data16 <= 16'h0000;
        end else if (i_FrameSync) begin
            o_Data16 <= w_shown;
        end
    end

    // Registered readback of the addressed register (pre-edge values).
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            o_RData <= 16'h0000;
        end else begin
            case (i_Addr)
                c_ADDR_DATA:   o_RData <= r_w;
                c_ADDR_MODE:   o_RData <= {13'd0, r_mode};
                c_ADDR_PERIOD: o_RData <= r_period;
                c_ADDR_STATUS: o_RData <= {r_frame, 6'd0, w_enable, r_phase};
                default:       o_RData <= 16'h0000;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_source
//  Purpose  : Directed self-checking bench for led_pattern_source (PRESCALE=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_source;

    logic        r_clk;
    logic        r_rst;
    logic        r_we;
    logic [1:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_fs;
    logic [15:0] w_rdata;
    logic [15:0] w_data16;

    int n_checks = 0;
    int n_pass   = 0;

    led_pattern_source #(.PRESCALE(4)) u_dut (
        .i_CLK       (r_clk),
        .i_RESET     (r_rst),
        .i_WE        (r_we),
        .i_Addr      (r_addr),
        .i_WData     (r_wdata),
        .o_RData     (w_rdata),
        .i_FrameSync (r_fs),
        .o_Data16    (w_data16)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge r_clk);
    endtask

    // Register write landing on the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        r_we = 1'b1; r_addr = a; r_wdata = d;
        cyc(1);
        r_we = 1'b0;
    endtask

    // Readback: value reflects register state just before the next edge.
    task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
        r_addr = a;
        cyc(1);
        check(tag, w_rdata, exp);
    endtask

    task automatic fs_pulse();
        r_fs = 1'b1;
        cyc(1);
        r_fs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_w;
        r_rst = 1'b1; r_we = 1'b0; r_addr = 2'd0; r_wdata = 16'h0; r_fs = 1'b0;
        cyc(3);
        r_rst = 1'b0;

        // Reset state
        check("rst_data16", w_data16, 16'h0000);
        rd("rst_w", 2'd0, 16'h0000);
        rd("rst_mode", 2'd1, 16'h0000);
        rd("rst_period", 2'd2, 16'h0001);
        rd("rst_status", 2'd3, 16'h0000);
        fs_pulse();
        check("idle_data16", w_data16, 16'h0000);
        wr(2'd3, 16'h0);

        // Static enabled pattern appears only at the frame pulse
        wr(2'd0, 16'hA5C3);
        wr(2'd1, 16'h0004);
        cyc(3);
        check("static_before_fs", w_data16, 16'h0000);
        fs_pulse();
        check("static_after_fs", w_data16, 16'hA5C3);
        rd("status_f1", 2'd3, 16'h0102);
        fs_pulse();
        cyc(10);
        check("static_stable", w_data16, 16'hA5C3);
        rd("status_f2", 2'd3, 16'h0202);

        // Rotate-left, PERIOD=2: one step per 8 cycles, wraps after 16 steps
        wr(2'd0, 16'h0001);
        wr(2'd2, 16'h0002);
        wr(2'd1, 16'h0006);
        rd("rotl_mode", 2'd1, 16'h0006);
        exp_w = 16'h0001;
        for (int k = 1; k <= 16; k++) begin
            cyc(7);
            exp_w = {exp_w[14:0], exp_w[15]};
            rd($sformatf("rotl_step%0d", k), 2'd0, exp_w);
        end
        check("rotl_wrapped", exp_w, 16'h0001);

        // DATA write in the very cycle a step fires: write wins, period restarts
        cyc(6);
        wr(2'd0, 16'h8000);
        rd("collide_w", 2'd0, 16'h8000);
        cyc(6);
        rd("collide_hold", 2'd0, 16'h8000);
        rd("collide_next", 2'd0, 16'h0001);

        // Blink, PERIOD=0, frame sync every cycle
        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'h0000);
        wr(2'd1, 16'h0005);
        r_fs = 1'b1;
        cyc(1);
        check("blink_on_a", w_data16, 16'h00FF);
        cyc(3);
        check("blink_on_b", w_data16, 16'h00FF);
        cyc(1);
        check("blink_off_a", w_data16, 16'h0000);
        cyc(3);
        check("blink_off_b", w_data16, 16'h0000);
        cyc(1);
        check("blink_on_c", w_data16, 16'h00FF);
        wr(2'd1, 16'h0001);
        check("disable_lag", w_data16, 16'h00FF);
        cyc(1);
        check("disable_blank", w_data16, 16'h0000);
        r_fs = 1'b0;

        // Frame counter wrap
        wr(2'd3, 16'h0);
        r_fs = 1'b1;
        cyc(255);
        r_fs = 1'b0;
        rd("frame_255", 2'd3, 16'hFF00);
        fs_pulse();
        rd("frame_wrap", 2'd3, 16'h0000);

        // Clear coincident with a frame pulse
        fs_pulse(); fs_pulse(); fs_pulse();
        rd("frame_3", 2'd3, 16'h0300);
        r_fs = 1'b1;
        wr(2'd3, 16'h0);
        r_fs = 1'b0;
        rd("frame_clear_wins", 2'd3, 16'h0000);

        // Reset mid-blink blanks the display immediately
        wr(2'd0, 16'h1234);
        wr(2'd2, 16'h0001);
        wr(2'd1, 16'h0005);
        r_fs = 1'b1;
        cyc(2);
        check("pre_reset_shown", w_data16, 16'h1234);
        r_fs = 1'b0;
        r_addr = 2'd2;
        r_rst = 1'b1;
        cyc(1);
        check("reset_data16", w_data16, 16'h0000);
        check("reset_rdata", w_rdata, 16'h0000);
        cyc(1);
        r_rst = 1'b0;
        rd("post_rst_w", 2'd0, 16'h0000);
        rd("post_rst_mode", 2'd1, 16'h0000);
        rd("post_rst_period", 2'd2, 16'h0001);
        rd("post_rst_status", 2'd3, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
